enc_lite_tx: RTL and testbench
==============================

// Module: enc_lite_tx
// PURPOSE
// - TX-path PCS encoder: lite control interface (idle/start/term/err flags + keep) -> 64b/66b block (head + 64b).
// - Mirrors the RX lite decoder: data_i uses the same block image the decoder emits (BT byte at [7:0], payload in place).
// - Runs the 802.3 cl.49 transmit sequence check (INIT/C/D/E); illegal sequences emit /E/ blocks.
// - Sits between MAC-side lite source and the scrambler/gearbox; one registered stage with valid/ready.
// PARAMETERS
// - IS_40G        0     1: 40G lane, START_4 forbidden
// - HEAD_W        2     sync header width
// - DATA_W        64    block payload width
// - KEEP_W        8     DATA_W/8, byte-valid mask width
// - LANE0_CNT_N   2     IS_40G ? 1 : 2; start positions (bit0 lane 0, bit1 lane 4)
// - BLOCK_TYPE_W  8     block type field width
// PORTS
// - clk        in   1            clock
// - rst        in   1            reset, asynchronous, active-high
// - valid_i    in   1            input word valid
// - ready_o    out  1            input accepted when valid_i & ready_o
// - ctrl_v_i   in   1            1: control block, 0: all-data block
// - idle_v_i   in   1            idle block
// - start_v_i  in   LANE0_CNT_N  start, one-hot position
// - term_v_i   in   1            terminate block
// - err_v_i    in   1            source-signalled error
// - keep_i     in   KEEP_W       term data bytes, thermometer from bit0 (0 = T0, 8'h7f = T7)
// - data_i     in   DATA_W       block image
// - valid_o    out  1            output block valid
// - ready_i    in   1            downstream (gearbox) ready
// - head_o     out  HEAD_W       sync header: 2'b01 data, 2'b10 ctrl
// - data_o     out  DATA_W       encoded block
// - seq_err_o  out  1            1 with valid_o when block is /E/ due to sequence/format violation
// BEHAVIOUR
// - Reset: valid_o=0, head_o=2'b10, data_o={56'h0,8'h1e}, seq_err_o=0, state=INIT.
// - Handshake: ready_o = ~valid_o | ready_i. Accept -> output reg loads next cycle (latency 1).
//   valid_o & ~ready_i: outputs and state held stable. No accept & ready_i: valid_o drops to 0.
// - Classify accepted word: ctrl_v_i=0 -> D. ctrl_v_i=1: exactly one of {idle, start, term, err} else E;
//   err -> E; start with >1 bit set, or start_v_i[1] when IS_40G -> E; term with non-thermometer keep_i -> E.
// - Encoding (head_o=2'b10 for all but D):
//   D: head 01, data_o=data_i.  C(idle): {56'h0,8'h1e}.  E: {8{7'h1e}},8'h1e.
//   S0: {data_i[63:8],8'h78}.  S4: {data_i[63:40],32'h0,8'h33}.
//   Tk (k=popcount keep_i): BT from table (T0 87,99,aa,b4,cc,d2,e1,T7 ff), data_i[8k+7:8] kept, rest 0.
// - FSM (advances only on accept): next-type -> state/output:
//   INIT: C->C, S->D, other->E.   C: C->C, S->D, other->E.
//   D: D->D, T->C (emit Tk), other->E.   E: C->C, S->D, D->D, T->C, E->E.
//   Any transition to E emits /E/ with seq_err_o=1; err_v_i-driven E also sets seq_err_o=1.
// - Simultaneous accept and output drain: output reg loads new block same edge, valid_o stays 1.
// - Reset mid-packet: state INIT; first post-reset D or T -> /E/.
// STRUCTURE
// - pcs_pkg: BLOCK_TYPE_* constants, SYNC_HEAD_CTRL/DATA, /E/ 7-bit code 7'h1e, tx_state_e {INIT,C,D,E}, blk_type_e {C,S,D,T,E}.
// - Sub-module enc_lite_blk: combinational classify + block image build; enc_lite_tx holds FSM, handshake, output reg.
// TESTING
// - Reset, idle stream ready_i=1 -> after 1 cyc head 10, data 64'h...001e each cycle, seq_err_o=0.
// - S0, 3x D(64'hA5..), T3 keep 8'h07 -> 10/..78, 01/A5.., 10/b4 with D0-D2 at [31:8], upper 0.
// - D while in C -> head 10, data {8{7'h1e}},8'h1e, seq_err_o=1; next idle -> normal idle block.
// - ready_i low 3 cyc mid-packet -> data_o/head_o frozen, ready_o=0, no word lost, order preserved.
// - IS_40G=1 with start_v_i[1]; also keep_i=8'h05 term -> both /E/ with seq_err_o=1.
// - rst pulsed mid-packet -> valid_o=0 immediately; following T -> /E/, then S0 -> 78 block.

Source files
------------

// File: rtl/pcs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcs_pkg                                                      |
// | Description : 64b/66b PCS constants, block/state enums, terminate BT map.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pcs_pkg;

    localparam logic [1:0] c_SYNC_HEAD_DATA = 2'b01;
    localparam logic [1:0] c_SYNC_HEAD_CTRL = 2'b10;

    localparam logic [7:0] c_BLOCK_TYPE_C  = 8'h1e;
    localparam logic [7:0] c_BLOCK_TYPE_S0 = 8'h78;
    localparam logic [7:0] c_BLOCK_TYPE_S4 = 8'h33;
    localparam logic [7:0] c_BLOCK_TYPE_T0 = 8'h87;
    localparam logic [7:0] c_BLOCK_TYPE_T1 = 8'h99;
    localparam logic [7:0] c_BLOCK_TYPE_T2 = 8'haa;
    localparam logic [7:0] c_BLOCK_TYPE_T3 = 8'hb4;
    localparam logic [7:0] c_BLOCK_TYPE_T4 = 8'hcc;
    localparam logic [7:0] c_BLOCK_TYPE_T5 = 8'hd2;
    localparam logic [7:0] c_BLOCK_TYPE_T6 = 8'he1;
    localparam logic [7:0] c_BLOCK_TYPE_T7 = 8'hff;

    localparam logic [6:0]  c_CTRL_E     = 7'h1e;
    localparam logic [63:0] c_BLOCK_IDLE = {56'h0, c_BLOCK_TYPE_C};
    localparam logic [63:0] c_BLOCK_E    = {{8{c_CTRL_E}}, c_BLOCK_TYPE_C};

    localparam int c_BLK_TYPE_W = 3;

    typedef enum logic [1:0] {
        TX_INIT = 2'd0,
        TX_C    = 2'd1,
        TX_D    = 2'd2,
        TX_E    = 2'd3
    } tx_state_e;

    typedef enum logic [2:0] {
        BLK_C = 3'd0,
        BLK_S = 3'd1,
        BLK_D = 3'd2,
        BLK_T = 3'd3,
        BLK_E = 3'd4
    } blk_type_e;

    function automatic logic [7:0] term_block_type(input logic [3:0] k);
        case (k)
            4'd0:    term_block_type = c_BLOCK_TYPE_T0;
            4'd1:    term_block_type = c_BLOCK_TYPE_T1;
            4'd2:    term_block_type = c_BLOCK_TYPE_T2;
            4'd3:    term_block_type = c_BLOCK_TYPE_T3;
            4'd4:    term_block_type = c_BLOCK_TYPE_T4;
            4'd5:    term_block_type = c_BLOCK_TYPE_T5;
            4'd6:    term_block_type = c_BLOCK_TYPE_T6;
            default: term_block_type = c_BLOCK_TYPE_T7;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_lite_blk.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : enc_lite_blk                                                 |
// | Description : Classifies a lite word and builds its 66b block image.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module enc_lite_blk
    import pcs_pkg::*;
#(
    parameter int IS_40G       = 0,
    parameter int HEAD_W       = 2,
    parameter int DATA_W       = 64,
    parameter int KEEP_W       = 8,
    parameter int LANE0_CNT_N  = 2,
    parameter int BLOCK_TYPE_W = 8
) (
    input  logic                    i_ctrl_v,
    input  logic                    i_idle_v,
    input  logic [LANE0_CNT_N-1:0]  i_start_v,
    input  logic                    i_term_v,
    input  logic                    i_err_v,
    input  logic [KEEP_W-1:0]       i_keep,
    input  logic [DATA_W-1:0]       i_data,
    output logic [c_BLK_TYPE_W-1:0] o_blk_type,
    output logic [HEAD_W-1:0]       o_head,
    output logic [DATA_W-1:0]       o_data
);

    localparam logic [KEEP_W-1:0] c_KEEP_ONE = KEEP_W'(1);

    blk_type_e               w_type;
    logic                    w_start_any;
    logic                    w_start_multi;
    logic                    w_start_lane4;
    logic                    w_start_bad;
    logic [2:0]              w_flag_cnt;
    logic                    w_keep_ok;
    logic [3:0]              w_term_cnt;
    logic [BLOCK_TYPE_W-1:0] w_term_bt;
    logic [DATA_W-1:0]       w_term_data;

    generate
        if (LANE0_CNT_N > 1) begin : g_lane4
            assign w_start_lane4 = i_start_v[1];
        end else begin : g_no_lane4
            assign w_start_lane4 = 1'b0;
        end
    endgenerate

    assign w_start_any   = |i_start_v;
    assign w_start_multi = ($countones(i_start_v) > 1);
    assign w_start_bad   = (IS_40G != 0) && w_start_lane4;
    assign w_flag_cnt    = 3'(i_idle_v) + 3'(w_start_any) + 3'(i_term_v) + 3'(i_err_v);
    // Thermometer from bit 0 with the top byte never set (T7 is at most 7 data bytes).
    assign w_keep_ok     = ((i_keep & (i_keep + c_KEEP_ONE)) == '0) && !i_keep[KEEP_W-1];
    assign w_term_cnt    = 4'($countones(i_keep));
    assign w_term_bt     = BLOCK_TYPE_W'(term_block_type(w_term_cnt));

    always_comb begin
        w_type = BLK_E;
        if (!i_ctrl_v) begin
            w_type = BLK_D;
        end else if (w_flag_cnt == 3'd1 && !i_err_v) begin
            if (i_idle_v) begin
                w_type = BLK_C;
            end else if (w_start_any) begin
                if (!w_start_multi && !w_start_bad) begin
                    w_type = BLK_S;
                end
            end else if (w_keep_ok) begin
                w_type = BLK_T;
            end
        end
    end

    // Byte j of a terminate block carries data exactly when keep bit j-1 is set.
    always_comb begin
        w_term_data = '0;
        for (int j = 1; j < KEEP_W; j++) begin
            if (i_keep[j-1]) begin
                w_term_data[8*j +: 8] = i_data[8*j +: 8];
            end
        end
        w_term_data[BLOCK_TYPE_W-1:0] = w_term_bt;
    end

    always_comb begin
        o_head = c_SYNC_HEAD_CTRL;
        o_data = c_BLOCK_E;
        case (w_type)
            BLK_D: begin
                o_head = c_SYNC_HEAD_DATA;
                o_data = i_data;
            end
            BLK_C: o_data = c_BLOCK_IDLE;
            BLK_S: begin
                if (i_start_v[0]) begin
                    o_data = {i_data[DATA_W-1:8], c_BLOCK_TYPE_S0};
                end else begin
                    o_data = {i_data[DATA_W-1:40], 32'h0, c_BLOCK_TYPE_S4};
                end
            end
            BLK_T:   o_data = w_term_data;
            default: o_data = c_BLOCK_E;
        endcase
    end

    assign o_blk_type = w_type;

endmodule
`default_nettype wire

// File: rtl/enc_lite_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : enc_lite_tx                                                  |
// | Description : Lite control -> 64b/66b TX encoder with sequence checking.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module enc_lite_tx
    import pcs_pkg::*;
#(
    parameter int IS_40G       = 0,
    parameter int HEAD_W       = 2,
    parameter int DATA_W       = 64,
    parameter int KEEP_W       = 8,
    parameter int LANE0_CNT_N  = 2,
    parameter int BLOCK_TYPE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   ctrl_v_i,
    input  logic                   idle_v_i,
    input  logic [LANE0_CNT_N-1:0] start_v_i,
    input  logic                   term_v_i,
    input  logic                   err_v_i,
    input  logic [KEEP_W-1:0]      keep_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [HEAD_W-1:0]      head_o,
    output logic [DATA_W-1:0]      data_o,
    output logic                   seq_err_o
);

    logic [c_BLK_TYPE_W-1:0] w_blk_type_raw;
    blk_type_e               w_blk_type;
    logic [HEAD_W-1:0]       w_blk_head;
    logic [DATA_W-1:0]       w_blk_data;

    tx_state_e               r_state;
    tx_state_e               w_state_nxt;
    logic                    w_emit_e;
    logic                    w_accept;

    logic                    r_valid;
    logic [HEAD_W-1:0]       r_head;
    logic [DATA_W-1:0]       r_data;
    logic                    r_seq_err;

    enc_lite_blk #(
        .IS_40G       (IS_40G),
        .HEAD_W       (HEAD_W),
        .DATA_W       (DATA_W),
        .KEEP_W       (KEEP_W),
        .LANE0_CNT_N  (LANE0_CNT_N),
        .BLOCK_TYPE_W (BLOCK_TYPE_W)
    ) u_blk (
        .i_ctrl_v   (ctrl_v_i),
        .i_idle_v   (idle_v_i),
        .i_start_v  (start_v_i),
        .i_term_v   (term_v_i),
        .i_err_v    (err_v_i),
        .i_keep     (keep_i),
        .i_data     (data_i),
        .o_blk_type (w_blk_type_raw),
        .o_head     (w_blk_head),
        .o_data     (w_blk_data)
    );

    assign w_blk_type = blk_type_e'(w_blk_type_raw);
    assign ready_o    = ~r_valid | ready_i;
    assign w_accept   = valid_i & ready_o;

    // The sequence only advances on an accepted word; a stalled output freezes it.
    always_comb begin
        w_state_nxt = r_state;
        w_emit_e    = 1'b0;
        if (w_accept) begin
            case (r_state)
                TX_INIT, TX_C: begin
                    case (w_blk_type)
                        BLK_C:   w_state_nxt = TX_C;
                        BLK_S:   w_state_nxt = TX_D;
                        default: begin w_state_nxt = TX_E; w_emit_e = 1'b1; end
                    endcase
                end
                TX_D: begin
                    case (w_blk_type)
                        BLK_D:   w_state_nxt = TX_D;
                        BLK_T:   w_state_nxt = TX_C;
                        default: begin w_state_nxt = TX_E; w_emit_e = 1'b1; end
                    endcase
                end
                TX_E: begin
                    case (w_blk_type)
                        BLK_C:   w_state_nxt = TX_C;
                        BLK_S:   w_state_nxt = TX_D;
                        BLK_D:   w_state_nxt = TX_D;
                        BLK_T:   w_state_nxt = TX_C;
                        default: begin w_state_nxt = TX_E; w_emit_e = 1'b1; end
                    endcase
                end
                default: begin w_state_nxt = TX_E; w_emit_e = 1'b1; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_head    <= c_SYNC_HEAD_CTRL;
            r_data    <= c_BLOCK_IDLE;
            r_seq_err <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_head    <= w_emit_e ? c_SYNC_HEAD_CTRL : w_blk_head;
            r_data    <= w_emit_e ? c_BLOCK_E : w_blk_data;
            r_seq_err <= w_emit_e;
        end else if (ready_i) begin
            r_valid   <= 1'b0;
        end
    end

    assign valid_o   = r_valid;
    assign head_o    = r_head;
    assign data_o    = r_data;
    assign seq_err_o = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_enc_lite_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_enc_lite_tx                                               |
// | Description : Scoreboard bench for enc_lite_tx (default and 40G builds).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_enc_lite_tx;

    localparam logic [1:0]  c_HD     = 2'b01;
    localparam logic [1:0]  c_HC     = 2'b10;
    localparam logic [63:0] c_IDLE   = 64'h0000_0000_0000_001e;
    localparam logic [63:0] c_EBLK   = {{8{7'h1e}}, 8'h1e};
    localparam logic [63:0] c_GARB   = 64'hdead_beef_cafe_f00d;

    typedef struct {
        logic [1:0]  head;
        logic [63:0] data;
        logic        err;
        string       nm;
    } exp_t;

    logic        clk, rst;
    logic        valid_i, valid40, ready_i, ready40;
    logic        ctrl_v_i, idle_v_i, term_v_i, err_v_i;
    logic [1:0]  start_v_i;
    logic [7:0]  keep_i;
    logic [63:0] data_i;
    logic        ready_o, valid_o, seq_err_o;
    logic [1:0]  head_o;
    logic [63:0] data_o;
    logic        rdy40, v40, e40;
    logic [1:0]  h40;
    logic [63:0] d40;

    exp_t q0[$];
    exp_t q40[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    enc_lite_tx dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .ctrl_v_i(ctrl_v_i), .idle_v_i(idle_v_i), .start_v_i(start_v_i),
        .term_v_i(term_v_i), .err_v_i(err_v_i), .keep_i(keep_i), .data_i(data_i),
        .valid_o(valid_o), .ready_i(ready_i), .head_o(head_o), .data_o(data_o),
        .seq_err_o(seq_err_o)
    );

    enc_lite_tx #(.IS_40G(1), .LANE0_CNT_N(2)) dut40 (
        .clk(clk), .rst(rst), .valid_i(valid40), .ready_o(rdy40),
        .ctrl_v_i(ctrl_v_i), .idle_v_i(idle_v_i), .start_v_i(start_v_i),
        .term_v_i(term_v_i), .err_v_i(err_v_i), .keep_i(keep_i), .data_i(data_i),
        .valid_o(v40), .ready_i(ready40), .head_o(h40), .data_o(d40),
        .seq_err_o(e40)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a block is consumed on every cycle where valid and ready meet.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && valid_o && ready_i) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL mon0_unexpected: got %h_%h expected no block", head_o, data_o);
            end else begin
                e = q0.pop_front();
                chk(e.nm, {head_o, data_o, seq_err_o}, {e.head, e.data, e.err});
            end
        end
    end

    always @(negedge clk) begin : mon40
        exp_t e;
        if (!rst && v40 && ready40) begin
            if (q40.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL mon40_unexpected: got %h_%h expected no block", h40, d40);
            end else begin
                e = q40.pop_front();
                chk(e.nm, {h40, d40, e40}, {e.head, e.data, e.err});
            end
        end
    end

    task automatic snd(input bit sel, input logic ctrl, input logic idle, input logic [1:0] start,
                       input logic term, input logic err, input logic [7:0] keep,
                       input logic [63:0] din, input logic [1:0] eh, input logic [63:0] ed,
                       input logic es, input string nm);
        exp_t e;
        bit   ok;
        ctrl_v_i = ctrl; idle_v_i = idle; start_v_i = start; term_v_i = term;
        err_v_i = err; keep_i = keep; data_i = din;
        if (sel) valid40 = 1'b1; else valid_i = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (sel ? rdy40 : ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL %s_accept: got ready_o=0 for 64 cycles expected accept", nm);
        end else begin
            e.head = eh; e.data = ed; e.err = es; e.nm = nm;
            if (sel) q40.push_back(e); else q0.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        valid40 = 1'b0;
    endtask

    task automatic idle_w(input bit sel, input string nm);
        snd(sel, 1, 1, 2'b00, 0, 0, 8'h00, c_GARB, c_HC, c_IDLE, 0, nm);
    endtask

    task automatic dat_w(input bit sel, input logic [63:0] d, input string nm);
        snd(sel, 0, 0, 2'b00, 0, 0, 8'h00, d, c_HD, d, 0, nm);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; valid40 = 1'b0; ready_i = 1'b1; ready40 = 1'b1;
        ctrl_v_i = 1'b0; idle_v_i = 1'b0; start_v_i = 2'b00; term_v_i = 1'b0;
        err_v_i = 1'b0; keep_i = 8'h00; data_i = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_head_o", head_o, c_HC);
        chk("rst_data_o", data_o, c_IDLE);
        chk("rst_seq_err_o", seq_err_o, 0);
        chk("rst_ready_o", ready_o, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // idle stream
        for (int i = 0; i < 3; i++) idle_w(0, "idle_stream");

        // S0, three data, T3
        snd(0, 1, 0, 2'b01, 0, 0, 8'h00, 64'h0102030405060708, c_HC, 64'h0102030405060778, 0, "s0");
        for (int i = 0; i < 3; i++) dat_w(0, 64'hA5A5A5A5A5A5A5A5, "data_a5");
        snd(0, 1, 0, 2'b00, 1, 0, 8'h07, 64'h1122334455667788, c_HC, 64'h00000000556677b4, 0, "t3");

        // D while in C, then recovery
        snd(0, 0, 0, 2'b00, 0, 0, 8'h00, 64'h1234, c_HC, c_EBLK, 1, "d_in_c_err");
        idle_w(0, "idle_after_err");

        // S4 and T0
        snd(0, 1, 0, 2'b10, 0, 0, 8'h00, 64'h1122334455667788, c_HC, 64'h1122330000000033, 0, "s4");
        snd(0, 1, 0, 2'b00, 1, 0, 8'h00, 64'hffffffffffffffff, c_HC, 64'h0000000000000087, 0, "t0");

        // format violations
        snd(0, 1, 1, 2'b00, 1, 0, 8'h00, c_GARB, c_HC, c_EBLK, 1, "two_flags_err");
        idle_w(0, "idle_rec1");
        snd(0, 1, 0, 2'b00, 0, 1, 8'h00, c_GARB, c_HC, c_EBLK, 1, "err_flag");
        idle_w(0, "idle_rec2");
        snd(0, 1, 0, 2'b11, 0, 0, 8'h00, c_GARB, c_HC, c_EBLK, 1, "start_multi_err");
        idle_w(0, "idle_rec3");

        // backpressure mid-packet
        fork
            begin
                snd(0, 1, 0, 2'b01, 0, 0, 8'h00, 64'h0102030405060708, c_HC, 64'h0102030405060778, 0, "bp_s0");
                dat_w(0, 64'h1111111111111111, "bp_d1");
                dat_w(0, 64'h2222222222222222, "bp_d2");
                dat_w(0, 64'h3333333333333333, "bp_d3");
                snd(0, 1, 0, 2'b00, 1, 0, 8'h7f, 64'hFEDCBA9876543210, c_HC, 64'hFEDCBA98765432ff, 0, "bp_t7");
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_ready_o", ready_o, 0);
                    chk("stall_out_frozen", {head_o, data_o, seq_err_o}, {c_HD, 64'h1111111111111111, 1'b0});
                    @(posedge clk);
                end
                #1 ready_i = 1'b1;
            end
        join

        // reset mid-packet
        snd(0, 1, 0, 2'b01, 0, 0, 8'h00, 64'h0102030405060708, c_HC, 64'h0102030405060778, 0, "pre_rst_s0");
        dat_w(0, 64'hA5A5A5A5A5A5A5A5, "pre_rst_d");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid_o", valid_o, 0);
        chk("midrst_data_o", {head_o, data_o}, {c_HC, c_IDLE});
        @(posedge clk); #1 rst = 1'b0;
        snd(0, 1, 0, 2'b00, 1, 0, 8'h07, 64'h1122334455667788, c_HC, c_EBLK, 1, "post_rst_t_err");
        snd(0, 1, 0, 2'b01, 0, 0, 8'h00, 64'h0102030405060708, c_HC, 64'h0102030405060778, 0, "post_rst_s0");
        snd(0, 1, 0, 2'b00, 1, 0, 8'h00, 64'h0, c_HC, 64'h0000000000000087, 0, "post_rst_t0");

        // 40G lane: lane-4 start and non-thermometer keep are both illegal
        idle_w(1, "g40_idle");
        snd(1, 1, 0, 2'b10, 0, 0, 8'h00, 64'h1122334455667788, c_HC, c_EBLK, 1, "g40_s4_err");
        idle_w(1, "g40_idle_rec");
        snd(1, 1, 0, 2'b01, 0, 0, 8'h00, 64'h0102030405060708, c_HC, 64'h0102030405060778, 0, "g40_s0");
        snd(1, 1, 0, 2'b00, 1, 0, 8'h05, 64'h1122334455667788, c_HC, c_EBLK, 1, "g40_keep05_err");
        idle_w(1, "g40_idle_end");

        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q40_drained", q40.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
